// File: rtl/reg_file_pkg.sv
// Shared constants and types for the parametrised CPU register file.
package reg_file_pkg;
    localparam int REG_DATA_W = 8;
    localparam int REG_ADDR_W = 3;

    typedef logic [REG_DATA_W-1:0] reg_data_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    function automatic int reg_depth(input int addr_w);
        return 1 << addr_w;
    endfunction
endpackage

// File: rtl/reg_file_param_if.sv
// Decoder/ALU-facing bus of the register file: write, reserve and two read ports.
interface reg_file_param_if
    import reg_file_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
);
    logic [DATA_W-1:0] IN;
    logic [ADDR_W-1:0] INADDRESS;
    logic              WRITE;
    logic [ADDR_W-1:0] OUT1ADDRESS;
    logic [ADDR_W-1:0] OUT2ADDRESS;
    logic [DATA_W-1:0] OUT1;
    logic [DATA_W-1:0] OUT2;
    logic              RESERVE;
    logic [ADDR_W-1:0] RESADDRESS;
    logic              OUT1VALID;
    logic              OUT2VALID;
    logic              ANYPENDING;

    modport master (
        output IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS, RESERVE, RESADDRESS,
        input  OUT1, OUT2, OUT1VALID, OUT2VALID, ANYPENDING
    );

    modport slave (
        input  IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS, RESERVE, RESADDRESS,
        output OUT1, OUT2, OUT1VALID, OUT2VALID, ANYPENDING
    );
endinterface

// File: rtl/reg_read_port.sv
// One combinational read port: mux, zero-register force and operand-valid.
// Optional write-through bypass is enabled by defining REG_FILE_BYPASS_EN.
module reg_read_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = REG_DATA_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int ZERO_REG = 0,
    localparam int DEPTH   = reg_depth(ADDR_W)
) (
    input  logic [DATA_W-1:0] regs_i [DEPTH],
    input  logic [DEPTH-1:0]  pending_i,
    input  logic [ADDR_W-1:0] addr_i,
`ifdef REG_FILE_BYPASS_EN
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
`endif
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);
    always_comb begin
        data_o  = regs_i[addr_i];
        valid_o = ~pending_i[addr_i];
`ifdef REG_FILE_BYPASS_EN
        // A same-cycle write supplies the operand even if a newer reserve is landing.
        if (!rst_i && wr_en_i && (wr_addr_i == addr_i)) begin
            data_o  = wr_data_i;
            valid_o = 1'b1;
        end
`endif
        if ((ZERO_REG != 0) && (addr_i == '0)) begin
            data_o  = '0;
            valid_o = 1'b1;
        end
    end
endmodule

// File: rtl/reg_file_param.sv
// Parametrised CPU register file with per-register pending scoreboard.
// Define REG_FILE_BYPASS_EN for same-cycle write-through on the read ports.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = REG_DATA_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int ZERO_REG = 0
) (
    input  logic             CLK,
    input  logic             RESET,
    reg_file_param_if.slave  bus
);
    localparam int DEPTH = reg_depth(ADDR_W);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  pending_q;
    logic [DEPTH-1:0]  pending_d;
    logic              wr_ok;
    logic              res_ok;

    assign wr_ok  = bus.WRITE   && !((ZERO_REG != 0) && (bus.INADDRESS  == '0));
    assign res_ok = bus.RESERVE && !((ZERO_REG != 0) && (bus.RESADDRESS == '0));

    // Reserve is applied after the write clear so a newer producer keeps the register pending.
    always_comb begin
        pending_d = pending_q;
        if (wr_ok)  pending_d[bus.INADDRESS]  = 1'b0;
        if (res_ok) pending_d[bus.RESADDRESS] = 1'b1;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            pending_q <= '0;
        end else begin
            if (wr_ok) regs_q[bus.INADDRESS] <= bus.IN;
            pending_q <= pending_d;
        end
    end

    assign bus.ANYPENDING = |pending_q;

    reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_rd1 (
        .regs_i    (regs_q),
        .pending_i (pending_q),
        .addr_i    (bus.OUT1ADDRESS),
`ifdef REG_FILE_BYPASS_EN
        .rst_i     (RESET),
        .wr_en_i   (bus.WRITE),
        .wr_addr_i (bus.INADDRESS),
        .wr_data_i (bus.IN),
`endif
        .data_o    (bus.OUT1),
        .valid_o   (bus.OUT1VALID)
    );

    reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_rd2 (
        .regs_i    (regs_q),
        .pending_i (pending_q),
        .addr_i    (bus.OUT2ADDRESS),
`ifdef REG_FILE_BYPASS_EN
        .rst_i     (RESET),
        .wr_en_i   (bus.WRITE),
        .wr_addr_i (bus.INADDRESS),
        .wr_data_i (bus.IN),
`endif
        .data_o    (bus.OUT2),
        .valid_o   (bus.OUT2VALID)
    );
endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: an 8-bit plain instance and a 16-bit zero-register instance
// share one stimulus stream and are compared against an array-based reference model.
module tb_reg_file_param;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        we, res;
    logic [2:0]  wa, ra, a1, a2;
    logic [15:0] din;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_reg  [2][8];
    logic [7:0]  m_pend [2];

    always #5 CLK = ~CLK;

    reg_file_param_if #(.DATA_W(8),  .ADDR_W(3)) bus0 ();
    reg_file_param_if #(.DATA_W(16), .ADDR_W(3)) bus1 ();

    assign bus0.IN = din[7:0];
    assign bus0.INADDRESS = wa;
    assign bus0.WRITE = we;
    assign bus0.RESERVE = res;
    assign bus0.RESADDRESS = ra;
    assign bus0.OUT1ADDRESS = a1;
    assign bus0.OUT2ADDRESS = a2;
    assign bus1.IN = din;
    assign bus1.INADDRESS = wa;
    assign bus1.WRITE = we;
    assign bus1.RESERVE = res;
    assign bus1.RESADDRESS = ra;
    assign bus1.OUT1ADDRESS = a1;
    assign bus1.OUT2ADDRESS = a2;

    reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) dut0 (
        .CLK(CLK), .RESET(RESET), .bus(bus0));
    reg_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) dut1 (
        .CLK(CLK), .RESET(RESET), .bus(bus1));

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] dmask(input int i, input logic [15:0] v);
        return (i == 0) ? {8'h00, v[7:0]} : v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = '0;
            for (int a = 0; a < 8; a++) m_reg[i][a] = '0;
        end
    endtask

    // Expected read as seen right now, given current inputs and model state.
    task automatic exp_rd(input int i, input logic [2:0] a, output logic [15:0] d, output logic v);
        if (i == 1 && a == 3'd0) begin
            d = '0;
            v = 1'b1;
        end else begin
            d = m_reg[i][a];
            v = !m_pend[i][a];
`ifdef REG_FILE_BYPASS_EN
            if (!RESET && we && wa == a) begin
                d = dmask(i, din);
                v = 1'b1;
            end
`endif
        end
    endtask

    task automatic model_update();
        if (!RESET) begin
            for (int i = 0; i < 2; i++) begin
                if (we && !(i == 1 && wa == 3'd0)) begin
                    m_reg[i][wa]  = dmask(i, din);
                    m_pend[i][wa] = 1'b0;
                end
                if (res && !(i == 1 && ra == 3'd0)) m_pend[i][ra] = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string ph);
        logic [15:0] d1, d2, o1, o2;
        logic        v1, v2, ov1, ov2, oap;
        for (int i = 0; i < 2; i++) begin
            exp_rd(i, a1, d1, v1);
            exp_rd(i, a2, d2, v2);
            o1  = (i == 0) ? {8'h00, bus0.OUT1} : bus1.OUT1;
            o2  = (i == 0) ? {8'h00, bus0.OUT2} : bus1.OUT2;
            ov1 = (i == 0) ? bus0.OUT1VALID : bus1.OUT1VALID;
            ov2 = (i == 0) ? bus0.OUT2VALID : bus1.OUT2VALID;
            oap = (i == 0) ? bus0.ANYPENDING : bus1.ANYPENDING;
            check($sformatf("%s i%0d out1", ph, i), o1, d1);
            check($sformatf("%s i%0d out2", ph, i), o2, d2);
            check($sformatf("%s i%0d valid1", ph, i), 16'(ov1), 16'(v1));
            check($sformatf("%s i%0d valid2", ph, i), 16'(ov2), 16'(v2));
            check($sformatf("%s i%0d anypend", ph, i), 16'(oap), 16'(m_pend[i] != 8'h00));
        end
    endtask

    task automatic set(input logic w, input logic [2:0] wa_, input logic [15:0] d,
                       input logic r, input logic [2:0] ra_, input logic [2:0] x1,
                       input logic [2:0] x2);
        we = w; wa = wa_; din = d; res = r; ra = ra_; a1 = x1; a2 = x2;
    endtask

    // Called just after a falling edge with inputs applied.
    task automatic step(input string ph);
        #1;
        check_all(ph);
        @(posedge CLK);
        model_update();
        @(negedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET = 1'b1;
        set(0, 0, 0, 0, 0, 0, 0);
        model_clear();
        #3;
        check_all("por");
        @(negedge CLK);
        RESET = 1'b0;

        set(1, 3, 16'd56, 0, 0, 3, 5);     step("wr3");
        set(0, 0, 0, 0, 0, 3, 5);          step("rd3");
        set(0, 0, 0, 1, 7, 7, 3);          step("res7");
        set(0, 0, 0, 0, 0, 7, 7);          step("pend7");
        set(1, 7, 16'd40, 0, 0, 7, 7);     step("wr7");
        set(0, 0, 0, 0, 0, 7, 2);          step("clr7");
        set(1, 1, 16'd50, 1, 1, 1, 1);     step("wrres1");
        set(0, 0, 0, 0, 0, 1, 1);          step("chk1");
        set(1, 0, 16'd85, 1, 0, 0, 3);     step("zero");
        set(0, 0, 0, 0, 0, 0, 0);          step("chk0");
        set(1, 4, 16'h1234, 0, 0, 1, 4);   step("byp4");
        set(0, 0, 0, 0, 0, 4, 4);          step("chk4");
        set(1, 2, 16'hbeef, 1, 6, 2, 6);   step("wr2res6");
        set(0, 0, 0, 0, 0, 2, 6);          step("chk26");

        for (int n = 0; n < 300; n++) begin
            set(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            step("rand");
        end

        // Asynchronous reset mid-cycle with a write and reserve pending on the bus.
        set(1, 2, 16'h5a5a, 1, 6, 2, 6);
        #2;
        RESET = 1'b1;
        model_clear();
        #1;
        check_all("rst_async");
        @(posedge CLK);
        model_update();
        @(negedge CLK);
        #1;
        check_all("rst_hold");
        RESET = 1'b0;
        set(0, 0, 0, 0, 0, 2, 6);
        @(negedge CLK);
        step("rst_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
